// File: rtl/spi_mem_master.sv
// SPI master issuing 16-bit {addr[6:0], rw, data[7:0]} frames, MSB first, with sclk idling low.
// Define SPI_MASTER_MISO_SYNC_EN to put a two-flop synchronizer in front of miso sampling.
module spi_mem_master #(
  parameter int CLK_DIV = 8,
  parameter int CS_GAP  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   frame_q, frame_d;
  logic          rw_q, rw_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rise_q, rise_d;
  logic          miso_s;
  logic          samp;

`ifdef SPI_MASTER_MISO_SYNC_EN
  // Sample strobe is delayed to line up with miso leaving the synchronizer.
  logic sync1_q, sync2_q, rise1_q, rise2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      rise1_q <= 1'b0;
      rise2_q <= 1'b0;
    end else begin
      sync1_q <= miso;
      sync2_q <= sync1_q;
      rise1_q <= rise_q;
      rise2_q <= rise1_q;
    end
  end

  assign miso_s = sync2_q;
  assign samp   = rise2_q;
`else
  assign miso_s = miso;
  assign samp   = rise_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    rw_d      = rw_q;
    shreg_d   = shreg_q;
    rdata_d   = rdata_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rise_d    = 1'b0;

    if (samp) shreg_d = {shreg_q[6:0], miso_s};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          frame_d   = {addr, rw, (rw ? 8'h00 : wdata)};
          rw_d      = rw;
          cnt_d     = '0;
          bit_cnt_d = 4'd0;
          cs_n_d    = 1'b0;
          mosi_d    = addr[6];
          busy_d    = 1'b1;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rise_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rise_d = 1'b1;
          end else begin
            // Frame rotates so the next bit is always at [14]; the last fall drives 0.
            sclk_d    = 1'b0;
            frame_d   = {frame_q[14:0], frame_q[15]};
            mosi_d    = (bit_cnt_q == 4'd15) ? 1'b0 : frame_q[14];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (rw_q) rdata_d = shreg_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= 4'd0;
      frame_q   <= 16'h0000;
      rw_q      <= 1'b0;
      shreg_q   <= 8'h00;
      rdata_q   <= 8'h00;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      rw_q      <= rw_d;
      shreg_q   <= shreg_d;
      rdata_q   <= rdata_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rise_q    <= rise_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign sclk  = sclk_q;
  assign cs_n  = cs_n_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: waveform model derived from frame timing formulas, plus a behavioural SPI memory slave.
module tb_spi_mem_master;
  localparam int CD     = 8;
  localparam int GAP    = 16;
  localparam int DONE_R = 1 + 33 * CD + GAP;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] wdata = 8'd0;
  logic       busy, done, sclk, cs_n, mosi;
  logic       miso = 1'b0;
  logic [7:0] rdata;

  int cyc = 0;
  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  spi_mem_master #(.CLK_DIV(CD), .CS_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory contents as seen by the slave and as expected by the model
  logic [7:0] slv_mem [128];
  logic [7:0] exp_mem [128];

  // Model state for the frame in flight
  logic        m_act = 1'b0;
  int          m_t = 0;
  logic [15:0] m_frame = 16'h0;
  logic        m_rw = 1'b0;
  logic [6:0]  m_addr = 7'd0;
  logic [7:0]  m_wd = 8'd0;
  logic [7:0]  m_rdata = 8'd0;
  logic        m_busy = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst_n === 1'b1 && start === 1'b1 && !m_busy) begin
      m_act   = 1'b1;
      m_t     = cyc;
      m_rw    = rw;
      m_addr  = addr;
      m_wd    = wdata;
      m_frame = {addr, rw, (rw ? 8'h00 : wdata)};
    end
  end

  always @(negedge clk) begin : model_cmp
    logic e_busy, e_done, e_cs, e_sclk, e_mosi;
    int r, h, f;
    e_busy = 1'b0; e_done = 1'b0; e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0;
    if (rst_n !== 1'b1) begin
      m_act   = 1'b0;
      m_rdata = 8'h00;
    end else if (m_act) begin
      r = cyc - m_t + 1;
      h = (r - 1) / CD;
      f = h / 2;
      if (r == DONE_R) begin
        e_done = 1'b1;
        m_act  = 1'b0;
        if (m_rw) m_rdata = exp_mem[m_addr];
        else exp_mem[m_addr] = m_wd;
      end else begin
        e_busy = 1'b1;
        e_cs   = (h >= 33);
        e_sclk = (h >= 1 && h <= 32 && (h % 2) == 1);
        e_mosi = (h <= 32 && f < 16) ? m_frame[4'(15 - f)] : 1'b0;
      end
    end
    m_busy = e_busy;
    chk("busy",  32'(busy),  32'(e_busy));
    chk("done",  32'(done),  32'(e_done));
    chk("cs_n",  32'(cs_n),  32'(e_cs));
    chk("sclk",  32'(sclk),  32'(e_sclk));
    chk("mosi",  32'(mosi),  32'(e_mosi));
    chk("rdata", 32'(rdata), 32'(m_rdata));
  end

  // Behavioural SPI memory slave: miso changes on falling edges, data on falls 8..15
  int         s_r = 0, s_f = 0;
  logic [15:0] s_in = 16'h0;
  logic [6:0] s_addr = 7'd0;
  logic       s_rd = 1'b0;

  always @(negedge cs_n) begin s_r = 0; s_f = 0; end

  always @(posedge sclk) if (cs_n === 1'b0) begin
    s_in = {s_in[14:0], mosi};
    s_r++;
    if (s_r == 8) begin s_addr = s_in[7:1]; s_rd = s_in[0]; end
    if (s_r == 16 && !s_rd) slv_mem[s_addr] = s_in[7:0];
  end

  always @(negedge sclk) if (cs_n === 1'b0) begin
    s_f++;
    if (s_f >= 8 && s_f <= 15 && s_rd) miso = slv_mem[s_addr][3'(15 - s_f)];
    else miso = 1'($urandom_range(0, 1));
  end

  // MOSI capture on rising sclk for literal bit-stream checks
  logic [15:0] cap = 16'h0;
  int          rises = 0;
  int          dcount = 0;

  always @(negedge cs_n) begin cap = 16'h0; rises = 0; end
  always @(posedge sclk) if (cs_n === 1'b0) begin cap = {cap[14:0], mosi}; rises++; end
  always @(negedge clk) if (done === 1'b1) dcount++;

  task automatic wait_done(input int ts, output int lat);
    lat = -1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc - ts + 1;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_xfer(input logic r, input logic [6:0] a, input logic [7:0] d, output int lat);
    int ts;
    @(negedge clk);
    rw = r; addr = a; wdata = d; start = 1'b1;
    @(posedge clk);
    #1 ts = cyc;
    @(negedge clk);
    start = 1'b0; rw = ~r; addr = ~a; wdata = ~d;
    wait_done(ts, lat);
  endtask

  initial begin
    int lat, ts, d0;
    for (int i = 0; i < 128; i++) begin
      slv_mem[i] = 8'(i * 37 + 11);
      exp_mem[i] = 8'(i * 37 + 11);
    end
    slv_mem[7'h12] = 8'hC3;
    exp_mem[7'h12] = 8'hC3;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cs_n",  32'(cs_n),  32'd1);
    chk("rst_sclk",  32'(sclk),  32'd0);
    chk("rst_mosi",  32'(mosi),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_rdata", 32'(rdata), 32'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Read addr 0x12: slave returns 0xC3
    do_xfer(1'b1, 7'h12, 8'h99, lat);
    chk("rd_rdata", 32'(rdata), 32'hC3);
    chk("rd_mosi",  32'(cap),   32'h2500);
    chk("rd_rises", rises,      16);
    chk("rd_lat",   lat,        281);

    // Reset at the 5th rising sclk edge of a write
    @(negedge clk);
    rw = 1'b0; addr = 7'h33; wdata = 8'h77; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      #1;
      if (rises >= 5) break;
    end
    chk("abort_reached", rises, 5);
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n",  32'(cs_n),  32'd1);
    chk("abort_sclk",  32'(sclk),  32'd0);
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_rdata", 32'(rdata), 32'h00);
    d0 = dcount;
    repeat (300) @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (300) @(negedge clk);
    #1 chk("abort_no_done", dcount - d0, 0);
    chk("abort_mem_kept", 32'(slv_mem[7'h33]), 32'(8'(8'h33 * 37 + 11)));

    // Write 0x5A to 0x12
    do_xfer(1'b0, 7'h12, 8'h5A, lat);
    chk("wr_mosi",  32'(cap),   32'h245A);
    chk("wr_rises", rises,      16);
    chk("wr_lat",   lat,        281);
    chk("wr_rdata", 32'(rdata), 32'h00);

    // start held high through a frame; second frame launched from the done cycle
    @(negedge clk);
    rw = 1'b0; addr = 7'h07; wdata = 8'hA5; start = 1'b1;
    @(posedge clk);
    #1 ts = cyc;
    d0 = dcount;
    @(negedge clk);
    addr = 7'h08; wdata = 8'h3C;
    wait_done(ts, lat);
    chk("b2b_lat1", lat,        281);
    chk("b2b_mosi1", 32'(cap),  32'h0EA5);
    @(posedge clk);
    #1 start = 1'b0;
    ts = cyc;
    chk("b2b_cs_n", 32'(cs_n), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(ts, lat);
    chk("b2b_lat2",  lat,       281);
    chk("b2b_mosi2", 32'(cap),  32'h103C);
    #1 chk("b2b_dones", dcount - d0, 2);

    // Loopback reads
    do_xfer(1'b1, 7'h07, 8'h00, lat);
    chk("lb_rd07", 32'(rdata), 32'hA5);
    do_xfer(1'b1, 7'h08, 8'hFF, lat);
    chk("lb_rd08", 32'(rdata), 32'h3C);
    do_xfer(1'b1, 7'h12, 8'h00, lat);
    chk("lb_rd12", 32'(rdata), 32'h5A);
    chk("lb_mosi", 32'(cap),   32'h2500);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/spi_mem_master.md
# spi_mem_master

SPI master that issues single-byte read and write transactions to the SPI memory peripheral. It drives SCLK, CS and MOSI, and samples MISO. It sits between on-chip logic (a test sequencer or CPU port) and the off-chip or on-board SPI memory pins. Each transaction is one 16-bit frame: a 7-bit address, a R/W bit, then one data byte, MSB first.

## Interface
Parameters:
- CLK_DIV, 8: system clocks per SCLK half-period; legal range ≥2, and ≥3 when SPI_MASTER_MISO_SYNC_EN is defined; the SPI memory's input conditioners require ≥8.
- CS_GAP, 16: system clocks CS stays high after a frame before `done`.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; accepted only while busy=0.
- rw  in  1  1=read, 0=write; latched on start.
- addr  in  7  memory address; latched on start.
- wdata  in  8  write data; latched on start, ignored for reads.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle completion pulse.
- rdata  out  8  last read byte.
- sclk  out  1  SPI clock, idles low.
- cs_n  out  1  chip select, active low.
- mosi  out  1  serial data to memory.
- miso  in  1  serial data from memory.

## Operation
- Reset values: cs_n=1, sclk=0, mosi=0, busy=0, done=0, rdata=0x00, state IDLE, all counters 0.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: start=1 latches frame = {addr, rw, (rw ? 8'h00 : wdata)}, then enters SETUP.
- SETUP: cs_n=0, sclk=0, mosi=frame[15]; lasts CLK_DIV clocks, then enters SHIFT.
- SHIFT: sclk toggles every CLK_DIV clocks, for 16 rising and 16 falling edges.
  - Rising edge k (k=1..16): sample MISO into the shift register LSB (shift left).
  - Falling edge k (k=1..15): mosi drives frame[15-k].
  - Falling edge 16: mosi=0. Enter HOLD.
- HOLD: sclk=0, cs_n=0 for CLK_DIV clocks; then cs_n=1 and enter GAP.
- GAP: CS_GAP clocks with cs_n=1, then done=1 and busy=0 in the same cycle; return to IDLE.
- rdata: for reads, loaded with the bits sampled on rising edges 9–16 in the done cycle. Unchanged after writes.
- MISO during the address phase is ignored.
- The latched rw/addr/wdata are immune to input changes after accept.
- start while busy=1 is ignored; no queuing.
- start in the done cycle is accepted, because busy=0 in that cycle.
- rst_n low mid-frame: outputs return to reset values immediately; no done pulse; the partial frame is abandoned.

## Timing
Let start be sampled at edge T.
- T+1: busy=1, cs_n=0, mosi=frame[15].
- Rising edge k: sclk goes high at T+1+(2k-1)·CLK_DIV.
- Falling edge k: sclk goes low at T+1+2k·CLK_DIV.
- cs_n rises at T+1+33·CLK_DIV.
- done and busy=0 at T+1+33·CLK_DIV+CS_GAP. With defaults this is T+281.
- mosi changes only in the falling-edge cycle, or at SETUP entry. It is stable a full half-period around each rising edge.
- MISO sample point: the rising-edge cycle itself, with no synchronizer.

## Configuration
- SPI_MASTER_MISO_SYNC_EN defined:
  - miso passes through a two-flop synchronizer before use.
  - Each sample is taken 2 clocks after the corresponding sclk rising edge.
  - Frame latency is unchanged.
- Not defined: raw miso is sampled in the rising-edge cycle.

## Test plan
- Write: addr=0x12, wdata=0x5A, rw=0 → MOSI bit stream 0x24 then 0x5A, MSB first. Exactly 16 sclk rising edges while cs_n=0. done at T+281. rdata stays 0x00.
- Read: addr=0x12, rw=1, with a behavioural slave returning 0xC3 on falling edges 8–15 → MOSI 0x25 then 0x00. rdata=0xC3 in the done cycle.
- start asserted every cycle during a frame → exactly one frame and one done pulse. A second start in the done cycle launches the next frame with cs_n falling at done+1.
- rst_n low at the 5th rising edge → cs_n=1 and sclk=0 with no clock edge. No done pulse. The next start produces a clean, complete frame.
- Loopback against the SPI memory with CLK_DIV=8:
  - Write 0xA5 to addr 0x07, then 0x3C to addr 0x08.
  - Read addr 0x07 → rdata=0xA5. Read addr 0x08 → rdata=0x3C.
  - Repeat with SPI_MASTER_MISO_SYNC_EN defined; results are identical.
